// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control for EX, with a
// WB-to-ID same-cycle bypass and load-use hazard detection (bubble + upstream stall).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idValid,
  input  logic [ADDR_W-1:0] idRs,
  input  logic [ADDR_W-1:0] idRt,
  input  logic [ADDR_W-1:0] idRd,
  input  logic              idUsesRt,
  input  logic [DATA_W-1:0] readDat1,
  input  logic [DATA_W-1:0] readDat2,
  input  logic [DATA_W-1:0] idImm,
  input  logic [CTRL_W-1:0] idCtrl,
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbWriteReg,
  input  logic [DATA_W-1:0] wbWriteData,
  input  logic              flush,
  input  logic              memBusy,
  output logic              exValid,
  output logic [ADDR_W-1:0] exRs,
  output logic [ADDR_W-1:0] exRt,
  output logic [ADDR_W-1:0] exRd,
  output logic [DATA_W-1:0] exA,
  output logic [DATA_W-1:0] exB,
  output logic [DATA_W-1:0] exImm,
  output logic [CTRL_W-1:0] exCtrl,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic signed [DATA_W-1:0] opA_p0;
  logic signed [DATA_W-1:0] opB_p0;
  logic                     loadUse_p0;

  logic                     vld_p1;
  logic        [ADDR_W-1:0] exRs_p1;
  logic        [ADDR_W-1:0] exRt_p1;
  logic        [ADDR_W-1:0] exRd_p1;
  logic signed [DATA_W-1:0] exA_p1;
  logic signed [DATA_W-1:0] exB_p1;
  logic signed [DATA_W-1:0] exImm_p1;
  logic        [CTRL_W-1:0] exCtrl_p1;
  logic        [CNT_W-1:0]  stallCnt_p1;

  // Stage p0: decode-side bypass and hazard detection
  always_comb begin
    opA_p0 = readDat1;
    opB_p0 = readDat2;
    if (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == idRs)) opA_p0 = wbWriteData;
    if (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == idRt)) opB_p0 = wbWriteData;
  end

  assign loadUse_p0 = vld_p1 && exCtrl_p1[1] && (exRt_p1 != '0) && idValid &&
                      ((exRt_p1 == idRs) || (idUsesRt && (exRt_p1 == idRt)));
  assign stall = memBusy || (loadUse_p0 && !flush);

  // Stage p1: EX-facing register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      exRs_p1     <= '0;
      exRt_p1     <= '0;
      exRd_p1     <= '0;
      exA_p1      <= '0;
      exB_p1      <= '0;
      exImm_p1    <= '0;
      exCtrl_p1   <= '0;
      stallCnt_p1 <= '0;
    end else if (!memBusy) begin
      if (flush || loadUse_p0) begin
        vld_p1    <= 1'b0;
        exRs_p1   <= '0;
        exRt_p1   <= '0;
        exRd_p1   <= '0;
        exA_p1    <= '0;
        exB_p1    <= '0;
        exImm_p1  <= '0;
        exCtrl_p1 <= '0;
        // A squashed hazard is not a real bubble, so it is not counted
        if (!flush) stallCnt_p1 <= satInc(stallCnt_p1);
      end else begin
        vld_p1    <= idValid;
        exRs_p1   <= idRs;
        exRt_p1   <= idRt;
        exRd_p1   <= idRd;
        exA_p1    <= opA_p0;
        exB_p1    <= opB_p0;
        exImm_p1  <= idImm;
        exCtrl_p1 <= idValid ? idCtrl : '0;
      end
    end
  end

  assign exValid    = vld_p1;
  assign exRs       = exRs_p1;
  assign exRt       = exRt_p1;
  assign exRd       = exRd_p1;
  assign exA        = exA_p1;
  assign exB        = exB_p1;
  assign exImm      = exImm_p1;
  assign exCtrl     = exCtrl_p1;
  assign stallCount = stallCnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idValid;
  logic [4:0]  idRs, idRt, idRd;
  logic        idUsesRt;
  logic [31:0] readDat1, readDat2, idImm;
  logic [9:0]  idCtrl;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;
  logic        flush, memBusy;
  logic        exValid;
  logic [4:0]  exRs, exRt, exRd;
  logic [31:0] exA, exB, exImm;
  logic [9:0]  exCtrl;
  logic        stall;
  logic [15:0] stallCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .idUsesRt(idUsesRt), .readDat1(readDat1), .readDat2(readDat2), .idImm(idImm),
    .idCtrl(idCtrl), .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg),
    .wbWriteData(wbWriteData), .flush(flush), .memBusy(memBusy), .exValid(exValid),
    .exRs(exRs), .exRt(exRt), .exRd(exRd), .exA(exA), .exB(exB), .exImm(exImm),
    .exCtrl(exCtrl), .stall(stall), .stallCount(stallCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic usesRt, input logic [9:0] ctrl);
    idValid  = v;
    idRs     = rs;
    idRt     = rt;
    idUsesRt = usesRt;
    idCtrl   = ctrl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; idValid = 0; idRs = 0; idRt = 0; idRd = 0; idUsesRt = 0;
    readDat1 = 0; readDat2 = 0; idImm = 0; idCtrl = 0;
    wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0; flush = 0; memBusy = 0;

    // Reset state, with live ID inputs present before release
    step();
    setId(1, 5'd3, 5'd4, 1, 10'h001);
    readDat1 = 32'h11; idRd = 5'd8; idImm = 32'hFFFF_FFF0;
    step();
    checkVal("rst_exValid", exValid, 0);
    checkVal("rst_exA", exA, 0);
    checkVal("rst_exCtrl", exCtrl, 0);
    checkVal("rst_stallCount", stallCount, 0);
    checkVal("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkVal("first_exValid", exValid, 1);
    checkVal("first_exA", exA, 32'h11);
    checkVal("first_exRs", exRs, 3);
    checkVal("first_exRd", exRd, 8);
    checkVal("first_exImm", exImm, 32'hFFFF_FFF0);
    checkVal("first_exCtrl", exCtrl, 10'h001);

    // Load-use on rs: lw rt=5 in EX, add rs=5 in ID
    setId(1, 5'd1, 5'd5, 0, 10'h003);
    step();
    setId(1, 5'd5, 5'd6, 1, 10'h001);
    #1 checkVal("lu_stall", stall, 1);
    step();
    checkVal("lu_bubble_valid", exValid, 0);
    checkVal("lu_bubble_ctrl", exCtrl, 0);
    checkVal("lu_count", stallCount, 1);
    checkVal("lu_stall_after", stall, 0);
    step();
    checkVal("lu_reissue_valid", exValid, 1);
    checkVal("lu_reissue_rs", exRs, 5);

    // rt matches but is not used as a source: no hazard
    setId(1, 5'd1, 5'd5, 0, 10'h003);
    step();
    setId(1, 5'd2, 5'd5, 0, 10'h001);
    #1 checkVal("nouse_stall", stall, 0);
    step();
    checkVal("nouse_valid", exValid, 1);
    checkVal("nouse_rt", exRt, 5);
    checkVal("nouse_count", stallCount, 1);

    // WB bypass on both operands, then mixed, then register 0 never bypassed
    wbRegWrite = 1; wbWriteReg = 5'd7; wbWriteData = 32'hDEAD;
    readDat1 = 0; readDat2 = 0;
    setId(1, 5'd7, 5'd7, 1, 10'h001);
    step();
    checkVal("byp_exA", exA, 32'hDEAD);
    checkVal("byp_exB", exB, 32'hDEAD);
    readDat2 = 32'h5678;
    setId(1, 5'd7, 5'd8, 1, 10'h001);
    step();
    checkVal("byp_mix_exA", exA, 32'hDEAD);
    checkVal("byp_mix_exB", exB, 32'h5678);
    wbWriteReg = 5'd0; readDat1 = 32'h1234;
    setId(1, 5'd0, 5'd0, 1, 10'h001);
    step();
    checkVal("byp_r0_exA", exA, 32'h1234);
    checkVal("byp_r0_exB", exB, 32'h5678);
    wbRegWrite = 0;

    // Flush beats load-use
    setId(1, 5'd1, 5'd5, 0, 10'h003);
    step();
    setId(1, 5'd5, 5'd6, 1, 10'h001);
    flush = 1;
    #1 checkVal("flush_stall", stall, 0);
    step();
    flush = 0;
    checkVal("flush_valid", exValid, 0);
    checkVal("flush_ctrl", exCtrl, 0);
    checkVal("flush_count", stallCount, 1);

    // idValid=0 loads a bubble without stalling
    setId(0, 5'd5, 5'd5, 1, 10'h003);
    #1 checkVal("inv_stall", stall, 0);
    step();
    checkVal("inv_valid", exValid, 0);
    checkVal("inv_ctrl", exCtrl, 0);

    // memBusy freeze for 3 cycles
    readDat1 = 32'hAAAA;
    setId(1, 5'd9, 5'd4, 1, 10'h001);
    step();
    checkVal("busy_pre_exA", exA, 32'hAAAA);
    memBusy = 1; readDat1 = 32'hBBBB;
    setId(1, 5'd10, 5'd4, 1, 10'h001);
    for (int i = 0; i < 3; i++) begin
      #1 checkVal("busy_stall", stall, 1);
      step();
      checkVal("busy_hold_exA", exA, 32'hAAAA);
      checkVal("busy_hold_exRs", exRs, 9);
      checkVal("busy_hold_valid", exValid, 1);
    end
    memBusy = 0;
    step();
    checkVal("busy_release_exA", exA, 32'hBBBB);
    checkVal("busy_release_exRs", exRs, 10);

    // Saturation of the bubble counter
    force dut.stallCnt_p1 = 16'hFFFE;
    #1 release dut.stallCnt_p1;
    for (int i = 0; i < 3; i++) begin
      setId(1, 5'd1, 5'd5, 0, 10'h003);
      step();
      setId(1, 5'd5, 5'd6, 1, 10'h001);
      step();
      checkVal("sat_count", stallCount, 16'hFFFF);
    end

    // Reset asserted mid-stall clears immediately; first edge after release loads
    setId(1, 5'd1, 5'd5, 0, 10'h003);
    step();
    setId(1, 5'd5, 5'd6, 1, 10'h001);
    #1 checkVal("mid_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    checkVal("mid_rst_valid", exValid, 0);
    checkVal("mid_rst_count", stallCount, 0);
    checkVal("mid_rst_stall", stall, 0);
    checkVal("mid_rst_ctrl", exCtrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkVal("mid_rel_valid", exValid, 1);
    checkVal("mid_rel_rs", exRs, 5);
    checkVal("mid_rel_count", stallCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Captures register-file read data (readDat1/readDat2), sign-extended immediate, register numbers and control bundle from decode, and presents them to EX one cycle later.
- Contains load-use hazard detection (bubble insertion plus upstream stall) and a WB-to-ID same-cycle bypass. The bypass is needed because regFile commits writes after the capturing clock edge.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-number width.
- CTRL_W, 10, control bundle width; bit0 = regWrite, bit1 = memRead, remaining bits opaque and passed through.
- CNT_W, 16, stall-statistics counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- idValid  in  1  ID holds a real instruction
- idRs  in  ADDR_W  rs field
- idRt  in  ADDR_W  rt field
- idRd  in  ADDR_W  rd field
- idUsesRt  in  1  instruction reads rt as a source
- readDat1  in  DATA_W  regFile port 1 data (rs)
- readDat2  in  DATA_W  regFile port 2 data (rt)
- idImm  in  DATA_W  sign-extended immediate
- idCtrl  in  CTRL_W  decoded control
- wbRegWrite  in  1  WB writing this cycle
- wbWriteReg  in  ADDR_W  WB destination
- wbWriteData  in  DATA_W  WB data
- flush  in  1  taken branch/jump resolved in EX; squash ID
- memBusy  in  1  downstream memory not ready; freeze
- exValid  out  1  EX slot valid
- exRs  out  ADDR_W  registered rs
- exRt  out  ADDR_W  registered rt
- exRd  out  ADDR_W  registered rd
- exA  out  DATA_W  registered operand A
- exB  out  DATA_W  registered operand B
- exImm  out  DATA_W  registered immediate
- exCtrl  out  CTRL_W  registered control
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- stallCount  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst_n low, async): all ex* outputs 0, exValid 0, stallCount 0. stall is combinational and evaluates to 0 while exValid=0 and memBusy=0.
- Bypass (combinational, pre-register):
  - opA = wbWriteData if wbRegWrite && wbWriteReg!=0 && wbWriteReg==idRs, else readDat1.
  - opB uses the same rule with idRt and readDat2.
  - Writes to register 0 are never bypassed.
- loadUse = exValid && exCtrl[1] && exRt!=0 && idValid && (exRt==idRs || (idUsesRt && exRt==idRt)).
- stall = memBusy || (loadUse && !flush).
- Per-edge update, in priority order:
  1. memBusy=1: hold every ex* register and stallCount unchanged.
  2. flush=1: load bubble. exValid=0, exCtrl=0; other fields don't-care, drive 0.
  3. loadUse=1: load bubble as in step 2, and stallCount += 1, saturating at all-ones.
  4. Otherwise: exValid<=idValid; exCtrl<=idValid ? idCtrl : 0; exA<=opA, exB<=opB, exImm<=idImm, exRs/exRt/exRd<=id fields.
- Latency: exactly 1 cycle from ID to EX when not frozen.
- A bubble never carries regWrite or memRead, so a bubble cannot trigger loadUse on the next cycle.
- flush and loadUse together: flush wins, stall=0, and stallCount does not increment.
- idValid=0: loads bubble (exCtrl=0) with no stall; loadUse cannot assert.
- Reset mid-stall: outputs clear immediately. The first edge after release performs a normal load.

Test Plan:
- Reset then release, idValid=1, idRs=3, readDat1=32'h11 -> next edge exValid=1, exA=32'h11; all outputs 0 before release.
- Cycle N: EX holds lw with exRt=5 (exCtrl[1]=1). ID holds add with idRs=5 -> stall=1; next edge exValid=0, exCtrl=0, stallCount=1; following cycle stall=0.
- Same as above but idUsesRt=0 and idRt=5, idRs=2 -> stall=0, no bubble.
- wbRegWrite=1, wbWriteReg=7, wbWriteData=32'hDEAD, idRs=7, idRt=7, readDat1/readDat2=0 -> exA=exB=32'hDEAD. Repeat with wbWriteReg=0, idRs=0 -> exA=readDat1.
- loadUse condition plus flush=1 -> stall=0, bubble loaded, stallCount unchanged. memBusy=1 for 3 cycles -> all ex* outputs hold and stall=1 throughout.
- Force stallCount to 16'hFFFE, apply 3 load-use bubbles -> count saturates at 16'hFFFF.
